// File: rtl/linear_pkg.sv
// Shared types and width helpers for the sliced linear-layer scheduler.
package linear_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } sched_state_t;

   // Index width for a range of n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pulse_delay.sv
// Fixed-depth delay line with async reset. An async reset empties it, so
// nothing that was in flight comes out after the reset.
module pulse_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [DEPTH];

   // Shift d one stage per clock; reset clears every stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: this array is reset on purpose; it holds control pulses that must be flushed on reset, unlike a data memory.
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage take its neighbour's old value, so the order of these lines does not matter.
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/linear_slice_sched.sv
// Scheduler for the sliced linear layer. It accepts a feature vector, then
// walks rows x slices x beats to drive the MAC array. It drains the MAC
// pipeline and then holds the result until downstream takes it.
module linear_slice_sched
   import linear_pkg::*;
#(
   parameter int N               = 24,
   parameter int M               = 16,
   parameter int NUM_SLICES      = 2,
   parameter int MUL_PER_FEATURE = 6,
   parameter int MAC_LAT         = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  feat_latch,
   output logic                  mac_en,
   output logic                  mac_clr,
   output logic                  mac_last,
   output logic [idx_w(N)-1:0]   feat_idx,
   output logic [idx_w(M)-1:0]   row_idx,
   output logic                  wb_en,
   output logic [idx_w(M)-1:0]   wb_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   // The divisors are guarded so that an illegal setting reaches the
   // parameter check below instead of failing on a divide by zero.
   localparam int NS_SAFE   = (NUM_SLICES < 1) ? 1 : NUM_SLICES;
   localparam int MPF_SAFE  = (MUL_PER_FEATURE < 1) ? 1 : MUL_PER_FEATURE;
   localparam int SLICE_LEN = N / NS_SAFE;
   localparam int BPS       = SLICE_LEN / MPF_SAFE;

   localparam int FW = idx_w(N);
   localparam int RW = idx_w(M);
   localparam int BW = idx_w(BPS);
   localparam int SW = idx_w(NUM_SLICES);
   localparam int DW = idx_w(MAC_LAT);

   localparam logic [BW-1:0] BEAT_MAX  = BW'(BPS - 1);
   localparam logic [SW-1:0] SLICE_MAX = SW'(NUM_SLICES - 1);
   localparam logic [RW-1:0] ROW_MAX   = RW'(M - 1);
   localparam logic [DW-1:0] DRAIN_MAX = DW'(MAC_LAT - 1);
   // With one slice of one beat, the first beat of a row is also its last.
   localparam logic          FIRST_IS_LAST = (NUM_SLICES == 1) && (BPS == 1);

   if (NUM_SLICES < 1 || MUL_PER_FEATURE < 1 || MAC_LAT < 1 || M < 1 || N < 1 ||
       (N % (NS_SAFE * MPF_SAFE)) != 0 || BPS < 1) begin : g_bad_params
      $error("linear_slice_sched: illegal parameters N=%0d M=%0d NUM_SLICES=%0d MUL_PER_FEATURE=%0d MAC_LAT=%0d",
             N, M, NUM_SLICES, MUL_PER_FEATURE, MAC_LAT);
      $fatal(1, "linear_slice_sched: N must be a multiple of NUM_SLICES*MUL_PER_FEATURE");
   end

   sched_state_t  state_q;
   logic [BW-1:0] beat_q;
   logic [SW-1:0] slice_q;
   logic [RW-1:0] row_q;
   logic [DW-1:0] drain_q;

   logic [BW-1:0] beat_n;
   logic [SW-1:0] slice_n;
   logic [RW-1:0] row_n;
   logic [FW-1:0] feat_idx_n;
   logic          clr_n;
   logic          last_n;
   logic          final_beat;

   // Next beat position. The inner counter wraps into the outer one, and the
   // MAC outputs for that position are decoded here.
   always_comb begin
      // NOTE: in combinational logic every output is given a default first, so no path leaves it unassigned and no latch is inferred.
      beat_n     = beat_q;
      slice_n    = slice_q;
      row_n      = row_q;
      final_beat = 1'b0;
      if (beat_q == BEAT_MAX) begin
         beat_n = '0;
         if (slice_q == SLICE_MAX) begin
            slice_n    = '0;
            row_n      = row_q + RW'(1);
            final_beat = (row_q == ROW_MAX);
         end else begin
            slice_n = slice_q + SW'(1);
         end
      end else begin
         beat_n = beat_q + BW'(1);
      end
      feat_idx_n = FW'(int'(slice_n) * SLICE_LEN + int'(beat_n) * MUL_PER_FEATURE);
      clr_n      = (slice_n == '0) && (beat_n == '0);
      last_n     = (slice_n == SLICE_MAX) && (beat_n == BEAT_MAX);
   end

   assign feat_latch = in_valid & in_ready;
   assign busy       = (state_q != IDLE);

   // Scheduler FSM: the state, the counters and the registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         slice_q   <= '0;
         row_q     <= '0;
         drain_q   <= '0;
         in_ready  <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         mac_last  <= 1'b0;
         feat_idx  <= '0;
         row_idx   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (feat_latch) begin
                  state_q  <= RUN;
                  in_ready <= 1'b0;
                  beat_q   <= '0;
                  slice_q  <= '0;
                  row_q    <= '0;
                  mac_en   <= 1'b1;
                  mac_clr  <= 1'b1;
                  mac_last <= FIRST_IS_LAST;
                  feat_idx <= '0;
                  row_idx  <= '0;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               if (final_beat) begin
                  state_q  <= DRAIN;
                  drain_q  <= '0;
                  mac_en   <= 1'b0;
                  mac_clr  <= 1'b0;
                  mac_last <= 1'b0;
                  feat_idx <= '0;
                  row_idx  <= '0;
               end else begin
                  beat_q   <= beat_n;
                  slice_q  <= slice_n;
                  row_q    <= row_n;
                  mac_clr  <= clr_n;
                  mac_last <= last_n;
                  feat_idx <= feat_idx_n;
                  row_idx  <= row_n;
               end
            end
            DRAIN: begin
               if (drain_q == DRAIN_MAX) begin
                  state_q   <= OUT;
                  out_valid <= 1'b1;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_q   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [RW:0] wb_bus;

   pulse_delay #(
      .DEPTH (MAC_LAT),
      .W     (RW + 1)
   ) u_wb_delay (
      .clk (clk),
      .rst (rst),
      .d   ({mac_last, row_idx}),
      .q   (wb_bus)
   );

   assign wb_en  = wb_bus[RW];
   assign wb_row = wb_bus[RW-1:0];

endmodule

// File: tb/tb_linear_slice_sched.sv
// Directed testbench for linear_slice_sched with a scoreboard. Two instances
// are used: the default configuration (a) and a single-slice, single-beat
// configuration (b).
module tb_linear_slice_sched;

   typedef struct {int cyc; int feat; int row; int clr; int last;} beat_t;
   typedef struct {int cyc; int row;} wb_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_asserts = 0;
   int   n_fail = 0;

   logic       in_valid_a = 1'b0, out_ready_a = 1'b1;
   logic       in_ready_a, feat_latch_a, mac_en_a, mac_clr_a, mac_last_a;
   logic [4:0] feat_idx_a;
   logic [3:0] row_idx_a, wb_row_a;
   logic       wb_en_a, out_valid_a, busy_a;

   logic       in_valid_b = 1'b0, out_ready_b = 1'b1;
   logic       in_ready_b, feat_latch_b, mac_en_b, mac_clr_b, mac_last_b;
   logic [4:0] feat_idx_b;
   logic [3:0] row_idx_b, wb_row_b;
   logic       wb_en_b, out_valid_b, busy_b;

   beat_t q_beat_a[$], q_beat_b[$];
   wb_t   q_wb_a[$],   q_wb_b[$];
   int    fl_cnt_a = 0;

   linear_slice_sched u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .feat_latch(feat_latch_a), .mac_en(mac_en_a), .mac_clr(mac_clr_a),
      .mac_last(mac_last_a), .feat_idx(feat_idx_a), .row_idx(row_idx_a),
      .wb_en(wb_en_a), .wb_row(wb_row_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .busy(busy_a)
   );

   linear_slice_sched #(.N(24), .M(16), .NUM_SLICES(1), .MUL_PER_FEATURE(24), .MAC_LAT(1)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .feat_latch(feat_latch_b), .mac_en(mac_en_b), .mac_clr(mac_clr_b),
      .mac_last(mac_last_b), .feat_idx(feat_idx_b), .row_idx(row_idx_b),
      .wb_en(wb_en_b), .wb_row(wb_row_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference schedule for one vector accepted in cycle t0.
   task automatic push_exp(input bit sel, input int t0, input int ns, input int mpf, input int lat);
      int slen, bps, bpr, i;
      beat_t b;
      wb_t   w;
      slen = 24 / ns;
      bps  = slen / mpf;
      bpr  = ns * bps;
      i    = 0;
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < ns; s++) begin
            for (int k = 0; k < bps; k++) begin
               b.cyc  = t0 + 1 + i;
               b.feat = s * slen + k * mpf;
               b.row  = r;
               b.clr  = (s == 0 && k == 0) ? 1 : 0;
               b.last = (s == ns - 1 && k == bps - 1) ? 1 : 0;
               if (sel) q_beat_b.push_back(b); else q_beat_a.push_back(b);
               i++;
            end
         end
         w.cyc = t0 + (r + 1) * bpr + lat;
         w.row = r;
         if (sel) q_wb_b.push_back(w); else q_wb_a.push_back(w);
      end
   endtask

   // Called just after a rising edge. Returns how many cycles passed before
   // the vector was accepted, and returns just after the accepting edge.
   task automatic send_vec(input bit sel, input bit hold, output int waited);
      bit found = 1'b0;
      waited = -1;
      if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if ((sel ? feat_latch_b : feat_latch_a) === 1'b1) begin
            found  = 1'b1;
            waited = k;
            break;
         end
         @(posedge clk); #1;
      end
      check("accept_seen", int'(found), 1);
      if (found) begin
         if (sel) push_exp(1'b1, cyc, 1, 24, 1);
         else     push_exp(1'b0, cyc, 2, 6, 2);
      end
      @(posedge clk); #1;
      if (sel) in_valid_b = hold; else in_valid_a = hold;
   endtask

   // Counts cycles after the accept until out_valid is first seen.
   task automatic wait_out(input bit sel, output int lat);
      lat = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if ((sel ? out_valid_b : out_valid_a) === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic chk_quiet(input string tag);
      check({tag, "_in_ready"},  int'(in_ready_a),   0);
      check({tag, "_feat_latch"},int'(feat_latch_a), 0);
      check({tag, "_mac_en"},    int'(mac_en_a),     0);
      check({tag, "_mac_clr"},   int'(mac_clr_a),    0);
      check({tag, "_mac_last"},  int'(mac_last_a),   0);
      check({tag, "_feat_idx"},  int'(feat_idx_a),   0);
      check({tag, "_row_idx"},   int'(row_idx_a),    0);
      check({tag, "_wb_en"},     int'(wb_en_a),      0);
      check({tag, "_wb_row"},    int'(wb_row_a),     0);
      check({tag, "_out_valid"}, int'(out_valid_a),  0);
      check({tag, "_busy"},      int'(busy_a),       0);
      check({tag, "_b_in_ready"},int'(in_ready_b),   0);
      check({tag, "_b_wb_en"},   int'(wb_en_b),      0);
   endtask

   always @(negedge clk) begin : mon_a
      beat_t e;
      wb_t   w;
      if (rst) begin
         if (feat_latch_a) fl_cnt_a++;
         if (mac_en_a) begin
            if (q_beat_a.size() == 0) check("a_beat_unexpected", 1, 0);
            else begin
               e = q_beat_a.pop_front();
               check("a_beat_cyc", cyc,                e.cyc);
               check("a_feat_idx", int'(feat_idx_a),  e.feat);
               check("a_row_idx",  int'(row_idx_a),   e.row);
               check("a_mac_clr",  int'(mac_clr_a),   e.clr);
               check("a_mac_last", int'(mac_last_a),  e.last);
            end
         end
         if (wb_en_a) begin
            if (q_wb_a.size() == 0) check("a_wb_unexpected", 1, 0);
            else begin
               w = q_wb_a.pop_front();
               check("a_wb_cyc", cyc,             w.cyc);
               check("a_wb_row", int'(wb_row_a), w.row);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      beat_t e;
      wb_t   w;
      if (rst) begin
         if (mac_en_b) begin
            if (q_beat_b.size() == 0) check("b_beat_unexpected", 1, 0);
            else begin
               e = q_beat_b.pop_front();
               check("b_beat_cyc", cyc,               e.cyc);
               check("b_feat_idx", int'(feat_idx_b), e.feat);
               check("b_row_idx",  int'(row_idx_b),  e.row);
               check("b_mac_clr",  int'(mac_clr_b),  e.clr);
               check("b_mac_last", int'(mac_last_b), e.last);
            end
         end
         if (wb_en_b) begin
            if (q_wb_b.size() == 0) check("b_wb_unexpected", 1, 0);
            else begin
               w = q_wb_b.pop_front();
               check("b_wb_cyc", cyc,             w.cyc);
               check("b_wb_row", int'(wb_row_b), w.row);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, waited, fl0;

      // Reset state, then in_ready rises one cycle after release.
      repeat (2) @(posedge clk);
      #1 chk_quiet("rst");
      rst = 1'b1;
      @(negedge clk) check("rel_in_ready_low", int'(in_ready_a), 0);
      @(negedge clk) check("rel_in_ready_high", int'(in_ready_a), 1);
      @(posedge clk); #1;

      // Test 1: one vector, out_ready held high.
      out_ready_a = 1'b1;
      send_vec(1'b0, 1'b0, waited);
      wait_out(1'b0, lat);
      check("t1_out_latency", lat, 67);
      check("t1_in_ready_busy", int'(in_ready_a), 0);
      check("t1_beats_left", q_beat_a.size(), 0);
      check("t1_wb_left", q_wb_a.size(), 0);
      @(negedge clk);
      check("t1_out_valid_drop", int'(out_valid_a), 0);
      check("t1_in_ready_back", int'(in_ready_a), 1);
      @(posedge clk); #1;

      // Test 2: out_ready held low for 10 cycles of out_valid.
      out_ready_a = 1'b0;
      send_vec(1'b0, 1'b0, waited);
      wait_out(1'b0, lat);
      check("t2_out_latency", lat, 67);
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         check("t2_out_valid_hold", int'(out_valid_a), 1);
         check("t2_in_ready_hold", int'(in_ready_a), 0);
      end
      #1 out_ready_a = 1'b1;
      @(negedge clk);
      check("t2_out_valid_drop", int'(out_valid_a), 0);
      check("t2_in_ready_back", int'(in_ready_a), 1);
      @(posedge clk); #1;

      // Test 3: in_valid kept high while busy is ignored until IDLE returns.
      fl0 = fl_cnt_a;
      send_vec(1'b0, 1'b1, waited);
      wait_out(1'b0, lat);
      check("t3_out_latency", lat, 67);
      check("t3_single_latch", fl_cnt_a, fl0 + 1);
      @(posedge clk); #1;
      send_vec(1'b0, 1'b0, waited);
      check("t3_reaccept_wait", waited, 0);
      wait_out(1'b0, lat);
      check("t3b_out_latency", lat, 67);
      check("t3_latch_total", fl_cnt_a, fl0 + 2);
      check("t3_beats_left", q_beat_a.size(), 0);
      @(posedge clk); #1;

      // Test 4: reset pulsed at RUN beat 30.
      send_vec(1'b0, 1'b0, waited);
      repeat (30) @(posedge clk);
      #1 check("t4_mac_en_pre", int'(mac_en_a), 1);
      check("t4_row_pre", int'(row_idx_a), 7);
      q_beat_a.delete();
      q_wb_a.delete();
      #1 rst = 1'b0;
      #1 chk_quiet("t4_rst");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk) check("t4_rel_in_ready_low", int'(in_ready_a), 0);
      @(negedge clk) check("t4_rel_in_ready_high", int'(in_ready_a), 1);
      @(posedge clk); #1;
      send_vec(1'b0, 1'b0, waited);
      wait_out(1'b0, lat);
      check("t4_out_latency", lat, 67);
      check("t4_beats_left", q_beat_a.size(), 0);
      check("t4_wb_left", q_wb_a.size(), 0);
      @(posedge clk); #1;

      // Test 5: one slice of one beat, MAC_LAT=1.
      send_vec(1'b1, 1'b0, waited);
      wait_out(1'b1, lat);
      check("t5_out_latency", lat, 18);
      check("t5_beats_left", q_beat_b.size(), 0);
      check("t5_wb_left", q_wb_b.size(), 0);
      @(negedge clk);
      check("t5_in_ready_back", int'(in_ready_b), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
